// File: rtl/iris_enc_pkg.sv
// Shared types and constants for the iris latency-coded spike encoder.
// Holds the FSM state type, the default parameter values and the
// cycle-counter width helper used by the top and the channel sub-module.
package iris_enc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_GAP    = 2'd2
  } enc_state_e;

  localparam int DEF_WIDTH         = 9;
  localparam int DEF_SAMPLE_LEN    = 80;
  localparam int DEF_PATTERN_DELAY = 5000;

  // Bits needed for a counter that must hold values up to max(a, b).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/iris_lat_chan.sv
// One latency-coding channel: feature register, spike-time compare and a
// one-shot event flop. The spike time is the feature clipped to the last
// window slot; with IRIS_ENC_INVERT_EN defined the slot is mirrored so that
// large features fire early.
module iris_lat_chan
  import iris_enc_pkg::*;
#(
  parameter int p_width      = DEF_WIDTH,
  parameter int p_sample_len = DEF_SAMPLE_LEN,
  parameter int p_cnt_w      = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_arm,
  input  logic [p_cnt_w-1:0] i_cnt_nxt,
  input  logic [p_width-1:0] i_feature,
  output logic               o_event
);

  localparam logic [31:0] LastSlot = 32'(p_sample_len - 1);

  logic [p_width-1:0] feat_q, feat_d;
  logic [31:0]        feat_ext;
  logic [p_cnt_w-1:0] t_min, t_spk;
  logic               event_q, event_d;

  // Select the feature in force next cycle and decide whether it fires then.
  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    feat_d   = i_load ? i_feature : feat_q;
    feat_ext = 32'(feat_d);
    t_min    = (feat_ext >= LastSlot) ? p_cnt_w'(LastSlot) : p_cnt_w'(feat_ext);
`ifdef IRIS_ENC_INVERT_EN
    t_spk    = p_cnt_w'(LastSlot) - t_min;
`else
    t_spk    = t_min;
`endif
    event_d  = i_arm && (i_cnt_nxt == t_spk);
  end

  // Feature register and one-shot spike flop.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      feat_q  <= '0;
      event_q <= 1'b0;
    end else begin
      feat_q  <= feat_d;
      event_q <= event_d;
    end
  end

  assign o_event = event_q;

endmodule

// File: rtl/iris_spike_encoder.sv
// Iris spike encoder top: accepts a 4-feature vector in IDLE, emits one
// latency-coded spike per channel during a p_sample_len-cycle window, then
// stays silent for p_pattern_delay cycles and pulses o_done on the last one.
// Optional build macro: IRIS_ENC_INVERT_EN (mirrored spike timing).
module iris_spike_encoder
  import iris_enc_pkg::*;
#(
  parameter int p_width         = DEF_WIDTH,
  parameter int p_sample_len    = DEF_SAMPLE_LEN,
  parameter int p_pattern_delay = DEF_PATTERN_DELAY
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [4*p_width-1:0] i_feature,
  input  logic [2:0]           i_label,
  output logic                 o_ready,
  output logic [4:1]           o_event,
  output logic [3:1]           o_label,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CntW = cnt_width(p_sample_len, p_pattern_delay);
  localparam logic [CntW-1:0] EncLast = CntW'(p_sample_len - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(p_pattern_delay - 1);

  enc_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      label_q, label_d;
  logic            done_q, done_d;
  logic            load;
  logic            arm;

  // Next-state, window/gap counter and label bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    label_d = label_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          load    = 1'b1;
          state_d = ST_ENCODE;
          cnt_d   = '0;
          label_d = i_label;
        end
      end
      ST_ENCODE: begin
        if (cnt_q == EncLast) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GapLast) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          label_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        label_d = '0;
      end
    endcase
    // Outputs are registered, so decide from the state/count of the next cycle.
    arm    = (state_d == ST_ENCODE);
    done_d = (state_d == ST_GAP) && (cnt_d == GapLast);
  end

  // State, counter, latched label and done pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      label_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      label_q <= label_d;
      done_q  <= done_d;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_chan
    iris_lat_chan #(
      .p_width     (p_width),
      .p_sample_len(p_sample_len),
      .p_cnt_w     (CntW)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_load   (load),
      .i_arm    (arm),
      .i_cnt_nxt(cnt_d),
      .i_feature(i_feature[k*p_width +: p_width]),
      .o_event  (o_event[k+1])
    );
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_busy  = (state_q != ST_IDLE);
  assign o_label = label_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_iris_spike_encoder.sv
// Self-checking bench for iris_spike_encoder (W=4, L=8, D=4).
// A timeline model predicts every output each cycle from the transfer cycle
// and the spike times; directed scenarios add absolute-time checks.
module tb_iris_spike_encoder;

  localparam int W = 4;
  localparam int L = 8;
  localparam int D = 4;

  logic         clk;
  logic         i_rst;
  logic         i_valid;
  logic [4*W-1:0] i_feature;
  logic [2:0]   i_label;
  logic         o_ready;
  logic [4:1]   o_event;
  logic [3:1]   o_label;
  logic         o_busy;
  logic         o_done;

  iris_spike_encoder #(
    .p_width        (W),
    .p_sample_len   (L),
    .p_pattern_delay(D)
  ) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_feature(i_feature),
    .i_label  (i_label),
    .o_ready  (o_ready),
    .o_event  (o_event),
    .o_label  (o_label),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model state: one pattern in flight, started (transferred) at cycle t0.
  int       cyc = 0;
  bit       act = 0;
  int       t0  = 0;
  int       tk[1:4];
  logic [2:0] lab_m;
  int       ev_cyc[1:4];
  int       done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int spike_t(input int f);
    int m;
    m = (f < L - 1) ? f : L - 1;
`ifdef IRIS_ENC_INVERT_EN
    return (L - 1) - m;
`else
    return m;
`endif
  endfunction

  function automatic bit model_busy(input int c);
    return act && (c - t0) >= 1 && (c - t0) <= L + D;
  endfunction

  task automatic compare_all();
    int         rel;
    bit         busy;
    logic [4:1] ev_exp;
    rel  = cyc - t0;
    busy = model_busy(cyc);
    for (int k = 1; k <= 4; k++) ev_exp[k] = busy && (rel == 1 + tk[k]);
    check("ready", 32'(o_ready), 32'(!busy));
    check("busy",  32'(o_busy),  32'(busy));
    check("done",  32'(o_done),  32'(busy && rel == L + D));
    check("label", 32'(o_label), busy ? 32'(lab_m) : 32'(0));
    check("event", 32'(o_event), 32'(ev_exp));
    for (int k = 1; k <= 4; k++) if (o_event[k] === 1'b1) ev_cyc[k] = cyc;
    if (o_done === 1'b1) done_cyc = cyc;
  endtask

  task automatic step(input bit v, input logic [4*W-1:0] f, input logic [2:0] l, input bit r);
    i_valid   = v;
    i_feature = f;
    i_label   = l;
    i_rst     = r;
    if (r) act = 0;
    else if (v && !model_busy(cyc)) begin
      act   = 1;
      t0    = cyc;
      lab_m = l;
      for (int k = 1; k <= 4; k++) tk[k] = spike_t(int'(f[(k-1)*W +: W]));
    end
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 3'($urandom), 1'b0);
  endtask

  task automatic clear_marks();
    for (int k = 1; k <= 4; k++) ev_cyc[k] = -1;
    done_cyc = -1;
  endtask

  function automatic logic [2:0] rand_label();
    return 3'b001 << $urandom_range(0, 2);
  endfunction

  int t_s;

  initial begin
    for (int k = 1; k <= 4; k++) tk[k] = 0;
    lab_m     = '0;
    i_rst     = 1'b1;
    i_valid   = 1'b0;
    i_feature = '0;
    i_label   = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all();  // reset state

    // Scenario 1: features {0,3,7,5}, label 010.
    clear_marks();
    t_s = cyc;
    step(1'b1, 16'h5730, 3'b010, 1'b0);
    idle_steps(14);
`ifdef IRIS_ENC_INVERT_EN
    check("s1_ev1", 32'(ev_cyc[1] - t_s), 32'd8);
    check("s1_ev2", 32'(ev_cyc[2] - t_s), 32'd5);
    check("s1_ev3", 32'(ev_cyc[3] - t_s), 32'd1);
    check("s1_ev4", 32'(ev_cyc[4] - t_s), 32'd3);
`else
    check("s1_ev1", 32'(ev_cyc[1] - t_s), 32'd1);
    check("s1_ev2", 32'(ev_cyc[2] - t_s), 32'd4);
    check("s1_ev3", 32'(ev_cyc[3] - t_s), 32'd8);
    check("s1_ev4", 32'(ev_cyc[4] - t_s), 32'd6);
`endif
    check("s1_done", 32'(done_cyc - t_s), 32'd12);

    // Scenario 2: saturating features {15,9,8,2}.
    clear_marks();
    t_s = cyc;
    step(1'b1, 16'h289F, 3'b100, 1'b0);
    idle_steps(14);
`ifdef IRIS_ENC_INVERT_EN
    check("s2_ev1", 32'(ev_cyc[1] - t_s), 32'd1);
    check("s2_ev4", 32'(ev_cyc[4] - t_s), 32'd6);
`else
    check("s2_ev1", 32'(ev_cyc[1] - t_s), 32'd8);
    check("s2_ev2", 32'(ev_cyc[2] - t_s), 32'd8);
    check("s2_ev3", 32'(ev_cyc[3] - t_s), 32'd8);
    check("s2_ev4", 32'(ev_cyc[4] - t_s), 32'd3);
`endif

    // Scenario 3: i_valid held high with changing data; busy-time data is ignored.
    for (int i = 0; i < 30; i++) step(1'b1, 16'($urandom), rand_label(), 1'b0);
    idle_steps(14);

    // Scenario 4: reset at T+3 abandons the pattern.
    clear_marks();
    t_s = cyc;
    step(1'b1, 16'hFFFF, 3'b001, 1'b0);
    idle_steps(2);
    step(1'b0, 16'($urandom), 3'($urandom), 1'b1);
    idle_steps(14);
    check("s4_no_done", 32'(done_cyc), 32'hFFFF_FFFF);

`ifdef IRIS_ENC_INVERT_EN
    // Scenario 5: mirrored timing, features {0,7,3,15}.
    clear_marks();
    t_s = cyc;
    step(1'b1, 16'hF370, 3'b010, 1'b0);
    idle_steps(14);
    check("s5_ev1", 32'(ev_cyc[1] - t_s), 32'd8);
    check("s5_ev2", 32'(ev_cyc[2] - t_s), 32'd1);
    check("s5_ev3", 32'(ev_cyc[3] - t_s), 32'd5);
    check("s5_ev4", 32'(ev_cyc[4] - t_s), 32'd1);
`endif

    // Randomized traffic with occasional resets, checked by the model every cycle.
    for (int p = 0; p < 40; p++) begin
      idle_steps($urandom_range(0, 3));
      for (int i = 0; i < 14; i++)
        step(1'($urandom), 16'($urandom), rand_label(), ($urandom_range(0, 29) == 0));
    end
    step(1'b0, '0, '0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/iris_spike_encoder.md
IRIS_SPIKE_ENCODER -- requirements
Module: iris_spike_encoder

Interface
REQ-001 SHALL have parameter p_width, default 9: bit width of each input feature value.
REQ-002 SHALL have parameter p_sample_len, default 80: encode window length in clock cycles (>=2).
REQ-003 SHALL have parameter p_pattern_delay, default 5000: silent gap in cycles after each window (>=1).
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_valid, input, 1 bit: feature vector and label are valid.
REQ-007 SHALL have port i_feature, input, 4*p_width bits: features 1..4, feature k at bits [k*p_width-1:(k-1)*p_width].
REQ-008 SHALL have port i_label, input, 3 bits: one-hot class label for the vector.
REQ-009 SHALL have port o_ready, output, 1 bit: encoder can accept a vector.
REQ-010 SHALL have port o_event, output, 4 bits ([4:1]): latency-coded spikes to the L1 event input.
REQ-011 SHALL have port o_label, output, 3 bits ([3:1]): label of the pattern in flight.
REQ-012 SHALL have port o_busy, output, 1 bit: high while encoding or gapping.
REQ-013 SHALL have port o_done, output, 1 bit: one-cycle pulse at pattern completion.

Function
REQ-014 SHALL implement FSM states IDLE, ENCODE and GAP.
REQ-015 SHALL drive o_ready high only in IDLE; a transfer occurs on a cycle where i_valid and o_ready are both high.
REQ-016 SHALL, on a transfer at cycle T, latch i_feature and i_label and enter ENCODE at T+1 with the window counter at 0.
REQ-017 SHALL compute spike time t_k = min(f_k, p_sample_len-1) for each channel, saturating with no wrap-around.
REQ-018 SHALL assert o_event[k] for exactly one cycle at T+1+t_k, which is one spike per channel per pattern.
REQ-019 SHALL assert all matching channels in the same cycle when several t_k are equal.
REQ-020 SHALL remain in ENCODE for exactly p_sample_len cycles, then enter GAP for exactly p_pattern_delay cycles with o_event = 0.
REQ-021 SHALL pulse o_done on the final GAP cycle and enter IDLE next, so o_ready rises at T+1+p_sample_len+p_pattern_delay.
REQ-022 SHALL hold o_label at the latched label in ENCODE and GAP, and drive it to 0 in IDLE.
REQ-023 SHALL set o_busy = 1 exactly in ENCODE or GAP.
REQ-024 SHALL ignore i_valid, i_feature and i_label outside IDLE, with no queuing.
REQ-025 SHALL drive all outputs from registers only, with no combinational path from any input to any output.
REQ-026 SHALL size the cycle counter to ceil(log2(max(p_sample_len, p_pattern_delay)+1)) bits.

Reset
REQ-027 SHALL, on i_rst, enter IDLE and clear the counter and latched data, with o_event=0, o_label=0, o_busy=0, o_done=0 and o_ready=1 in the following cycle.
REQ-028 SHALL abandon any pattern in flight when i_rst asserts mid-operation, with no further spike or o_done for that pattern.

Configuration
REQ-029 SHALL, when macro IRIS_ENC_INVERT_EN is defined, use t_k = (p_sample_len-1) - min(f_k, p_sample_len-1), so large values spike early.
REQ-030 SHALL, when IRIS_ENC_INVERT_EN is undefined, use REQ-017 unchanged; all other behaviour is identical either way.

Structure
REQ-031 SHALL place the FSM state type, the counter-width function and the default parameter constants in shared package iris_enc_pkg.
REQ-032 SHALL instantiate sub-module iris_lat_chan four times, each holding one feature register, its spike-time compare and its one-shot output flop.

Verification
REQ-033 SHALL use bench parameters p_width=4, p_sample_len=8, p_pattern_delay=4 for all scenarios below.
REQ-034 SHALL check: features {0,3,7,5}, label 3'b010, transfer at T -> o_event[1]@T+1, [2]@T+4, [3]@T+8, [4]@T+6, o_label=010 over T+1..T+12, o_done@T+12, o_ready@T+13.
REQ-035 SHALL check: features {15,9,8,2} -> channels 1-3 saturate and spike together @T+8, o_event[4]@T+3, one pulse each.
REQ-036 SHALL check: i_valid held high continuously -> next transfer only at T+13 and second-vector data unaffected by inputs presented during busy.
REQ-037 SHALL check: i_rst asserted at T+3 of a pattern -> IDLE next cycle, o_event stays 0 for the rest of that pattern, no o_done, o_ready=1.
REQ-038 SHALL check: with IRIS_ENC_INVERT_EN, features {0,7,3,15} -> spikes @T+8, T+1, T+5, T+1.
